uart_top: RTL and testbench

// - UART front end: oversampling receiver + transmitter sharing one baud-tick generator.
// - Each received byte is pushed into a host-readable RX FIFO and into a TX FIFO. The TX FIFO

---
 rtl/uart_top.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_top.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// UART echo relay: 16x oversampled RX and TX sharing one baud tick,
// with a host-readable RX FIFO and a TX FIFO that loops bytes back out.
module uart_top #(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BIT_TICK = 16,
  parameter int BR_LIMIT      = 326,
  parameter int BR_BITS       = 9,
  parameter int FIFO_EXP      = 4
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 read_uart,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic [DATA_BITS-1:0] fifo_data_out
);

  localparam int SW =
    (STOP_BIT_TICK > 16) ? $clog2(STOP_BIT_TICK) : 4;
  localparam int NW =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int DEPTH = 2 ** FIFO_EXP;

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  logic               tick;
  logic [BR_BITS-1:0] br_cnt;

  assign tick = (br_cnt == BR_BITS'(BR_LIMIT - 1));

  always_ff @(posedge clk_50MHz) begin
    if (!reset)     br_cnt <= '0;
    else if (tick)  br_cnt <= '0;
    else            br_cnt <= br_cnt + 1'b1;
  end

  logic rx_m, rx_s;

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  state_t                rs, rs_n;
  logic [SW-1:0]         rsc, rsc_n;
  logic [NW-1:0]         rn, rn_n;
  logic [DATA_BITS-1:0]  rb, rb_n;
  logic                  data_ready;

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      rs  <= IDLE;
      rsc <= '0;
      rn  <= '0;
      rb  <= '0;
    end else begin
      rs  <= rs_n;
      rsc <= rsc_n;
      rn  <= rn_n;
      rb  <= rb_n;
    end
  end

  always_comb begin
    rs_n       = rs;
    rsc_n      = rsc;
    rn_n       = rn;
    rb_n       = rb;
    data_ready = 1'b0;
    unique case (rs)
      IDLE: begin
        if (!rx_s) begin
          rs_n  = START;
          rsc_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (rsc == SW'(7)) begin
            rsc_n = '0;
            rn_n  = '0;
            // line back high at mid start bit: treat as a glitch
            rs_n  = rx_s ? IDLE : DATA;
          end else begin
            rsc_n = rsc + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (rsc == SW'(15)) begin
            rsc_n = '0;
            rb_n  = {rx_s, rb[DATA_BITS-1:1]};
            if (rn == NW'(DATA_BITS - 1)) rs_n = STOP;
            else                          rn_n = rn + 1'b1;
          end else begin
            rsc_n = rsc + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rsc == SW'(STOP_BIT_TICK - 1)) begin
            rs_n       = IDLE;
            data_ready = 1'b1;
          end else begin
            rsc_n = rsc + 1'b1;
          end
        end
      end
      default: rs_n = IDLE;
    endcase
  end

  // index 0 is the host RX FIFO, index 1 feeds the transmitter
  logic                 tx_pop;
  logic [1:0]           f_rd, f_full, f_empty;
  logic [DATA_BITS-1:0] f_dout [2];

  assign f_rd = {tx_pop, read_uart};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_EXP-1:0]  wp, rp, wn, rn_p;
    logic                 full_q, empty_q;
    logic                 rd_ok, wr_ok;

    assign wn    = wp + 1'b1;
    assign rn_p  = rp + 1'b1;
    assign rd_ok = f_rd[g] & ~empty_q;
    assign wr_ok = data_ready & (~full_q | rd_ok);

    always_ff @(posedge clk_50MHz) begin
      if (wr_ok) mem[wp] <= rb;
    end

    always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
        wp      <= '0;
        rp      <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        if (wr_ok) wp <= wn;
        if (rd_ok) rp <= rn_p;
        if (wr_ok && !rd_ok) begin
          empty_q <= 1'b0;
          full_q  <= (wn == rp);
        end else if (rd_ok && !wr_ok) begin
          full_q  <= 1'b0;
          empty_q <= (rn_p == wp);
        end
      end
    end

    assign f_full[g]  = full_q;
    assign f_empty[g] = empty_q;
    assign f_dout[g]  = empty_q ? '0 : mem[rp];
  end

  assign fifo_full     = f_full[0];
  assign fifo_empty    = f_empty[0];
  assign fifo_data_out = f_dout[0];

  state_t               ts, ts_n;
  logic [SW-1:0]        tsc, tsc_n;
  logic [NW-1:0]        tn, tn_n;
  logic [DATA_BITS-1:0] tb, tb_n;
  logic                 txr, tx_n;

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      ts  <= IDLE;
      tsc <= '0;
      tn  <= '0;
      tb  <= '0;
      txr <= 1'b1;
    end else begin
      ts  <= ts_n;
      tsc <= tsc_n;
      tn  <= tn_n;
      tb  <= tb_n;
      txr <= tx_n;
    end
  end

  always_comb begin
    ts_n   = ts;
    tsc_n  = tsc;
    tn_n   = tn;
    tb_n   = tb;
    tx_n   = 1'b1;
    tx_pop = 1'b0;
    unique case (ts)
      IDLE: begin
        if (!f_empty[1]) begin
          tx_pop = 1'b1;
          tb_n   = f_dout[1];
          tsc_n  = '0;
          ts_n   = START;
          tx_n   = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (tick) begin
          if (tsc == SW'(15)) begin
            tsc_n = '0;
            tn_n  = '0;
            ts_n  = DATA;
            tx_n  = tb[0];
          end else begin
            tsc_n = tsc + 1'b1;
          end
        end
      end
      DATA: begin
        tx_n = tb[0];
        if (tick) begin
          if (tsc == SW'(15)) begin
            tsc_n = '0;
            tb_n  = tb >> 1;
            tx_n  = tb[1 % DATA_BITS];
            if (tn == NW'(DATA_BITS - 1)) begin
              ts_n = STOP;
              tx_n = 1'b1;
            end else begin
              tn_n = tn + 1'b1;
            end
          end else begin
            tsc_n = tsc + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tsc == SW'(STOP_BIT_TICK - 1)) ts_n = IDLE;
          else                               tsc_n = tsc + 1'b1;
        end
      end
      default: ts_n = IDLE;
    endcase
  end

  assign tx = txr;

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: reset, baud tick, echo, FIFO read,
// overflow, glitch rejection and reset in the middle of a frame.
module tb_uart_top;

  localparam int BRL = 8;
  localparam int BIT = 16 * BRL;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       tx;
  logic       read_uart;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_data_out;

  logic       tx0, full0, empty0;
  logic [7:0] dout0;

  int total = 0;
  int bad   = 0;
  int dr_cnt = 0;
  int tx_low = 0;
  bit mon_en = 0;
  logic [7:0] echo_q [$];

  uart_top #(.BR_LIMIT(BRL), .BR_BITS(3)) dut (
    .clk_50MHz    (clk),
    .reset        (reset),
    .rx           (rx),
    .tx           (tx),
    .read_uart    (read_uart),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out)
  );

  // full-rate instance for checking the real tick period
  uart_top dut0 (
    .clk_50MHz    (clk),
    .reset        (reset),
    .rx           (1'b1),
    .tx           (tx0),
    .read_uart    (1'b0),
    .fifo_full    (full0),
    .fifo_empty   (empty0),
    .fifo_data_out(dout0)
  );

  initial clk = 0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (dut.data_ready) dr_cnt++;
    if (mon_en && tx === 1'b0) tx_low++;
  end

  initial begin : monitor
    logic [7:0] b;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (BIT / 2 - 1) @(negedge clk);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin
          bad++;
          $display("FAIL echo_stop got=%b exp=1", tx);
        end
        echo_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT * (1 + gap)) @(negedge clk);
  endtask

  task automatic pop;
    read_uart = 1'b1;
    @(negedge clk);
    read_uart = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_echo(input int n, input int budget);
    int w;
    w = 0;
    while (echo_q.size() < n && w < budget) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx = 1'b1;
    read_uart = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL rst_tx got=%b exp=1", tx);
    end
    total++;
    if (fifo_empty !== 1'b1) begin
      bad++; $display("FAIL rst_empty got=%b exp=1", fifo_empty);
    end
    total++;
    if (fifo_full !== 1'b0) begin
      bad++; $display("FAIL rst_full got=%b exp=0", fifo_full);
    end
    total++;
    if (fifo_data_out !== 8'h00) begin
      bad++; $display("FAIL rst_dout got=%h exp=00", fifo_data_out);
    end
    total++;
    if (tx0 !== 1'b1 || empty0 !== 1'b1 || full0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_dut0 got=%b%b%b exp=110",
               tx0, empty0, full0);
    end
    reset = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_tick;
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!dut0.tick && n < 1000);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!dut0.tick && n < 1000);
      total++;
      if (n != 326) begin
        bad++; $display("FAIL tick_period got=%0d exp=326", n);
      end
    end
  endtask

  task automatic test_echo;
    logic [7:0] exp_b [3];
    exp_b = '{8'h41, 8'h42, 8'h43};
    echo_q.delete();
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], 5);
    wait_echo(3, 20 * BIT);
    total++;
    if (echo_q.size() != 3) begin
      bad++;
      $display("FAIL echo_count got=%0d exp=3", echo_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= echo_q.size() || echo_q[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL echo_byte%0d got=%h exp=%h", i,
                 (i < echo_q.size()) ? echo_q[i] : 8'hxx,
                 exp_b[i]);
      end
    end
    repeat (2 * BIT) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin
      bad++; $display("FAIL echo_idle got=%b exp=1", tx);
    end
  endtask

  task automatic test_fifo_read;
    logic [7:0] exp_b [4];
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h00};
    total++;
    if (fifo_empty !== 1'b0) begin
      bad++; $display("FAIL rd_empty got=%b exp=0", fifo_empty);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fifo_data_out !== exp_b[i]) begin
        bad++;
        $display("FAIL rd_head%0d got=%h exp=%h", i,
                 fifo_data_out, exp_b[i]);
      end
      if (i < 3) pop();
    end
    total++;
    if (fifo_empty !== 1'b1) begin
      bad++; $display("FAIL rd_drained got=%b exp=1", fifo_empty);
    end
  endtask

  task automatic test_overflow;
    echo_q.delete();
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1);
    total++;
    if (fifo_full !== 1'b1) begin
      bad++; $display("FAIL ovf_full got=%b exp=1", fifo_full);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (fifo_data_out !== 8'(i)) begin
        bad++;
        $display("FAIL ovf_head%0d got=%h exp=%h", i,
                 fifo_data_out, 8'(i));
      end
      pop();
    end
    total++;
    if (fifo_empty !== 1'b1 || fifo_data_out !== 8'h00) begin
      bad++;
      $display("FAIL ovf_drained got=%b/%h exp=1/00",
               fifo_empty, fifo_data_out);
    end
    wait_echo(17, 30 * BIT);
    total++;
    if (echo_q.size() != 17) begin
      bad++;
      $display("FAIL ovf_echo_count got=%0d exp=17",
               echo_q.size());
    end
    for (int i = 0; i < 17 && i < echo_q.size(); i++) begin
      total++;
      if (echo_q[i] !== 8'(i)) begin
        bad++;
        $display("FAIL ovf_echo%0d got=%h exp=%h", i,
                 echo_q[i], 8'(i));
      end
    end
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic test_glitch;
    int dr0, lo0;
    echo_q.delete();
    dr0 = dr_cnt;
    lo0 = tx_low;
    rx = 1'b0;
    repeat (3 * BRL) @(negedge clk);
    rx = 1'b1;
    repeat (20 * BIT) @(negedge clk);
    total++;
    if (dr_cnt != dr0) begin
      bad++;
      $display("FAIL glitch_ready got=%0d exp=0", dr_cnt - dr0);
    end
    total++;
    if (fifo_empty !== 1'b1) begin
      bad++; $display("FAIL glitch_empty got=%b exp=1", fifo_empty);
    end
    total++;
    if (tx_low != lo0 || echo_q.size() != 0) begin
      bad++;
      $display("FAIL glitch_tx got=%0d low cycles exp=0",
               tx_low - lo0);
    end
  endtask

  task automatic test_reset_midframe;
    int dr0;
    logic [7:0] b;
    b = 8'hA5;
    echo_q.delete();
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[3];
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    dr0 = dr_cnt;
    repeat (12 * BIT) @(negedge clk);
    total++;
    if (fifo_empty !== 1'b1 || dr_cnt != dr0) begin
      bad++;
      $display("FAIL mid_abandon got=%b/%0d exp=1/0",
               fifo_empty, dr_cnt - dr0);
    end
    send_byte(8'h55, 2);
    total++;
    if (fifo_data_out !== 8'h55) begin
      bad++;
      $display("FAIL mid_rx got=%h exp=55", fifo_data_out);
    end
    wait_echo(1, 20 * BIT);
    total++;
    if (echo_q.size() != 1 || echo_q[0] !== 8'h55) begin
      bad++;
      $display("FAIL mid_echo got=%h n=%0d exp=55",
               (echo_q.size() > 0) ? echo_q[0] : 8'hxx,
               echo_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_echo();
    test_fifo_read();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
